drive_sequencer: RTL and testbench

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_drive_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// drive_sequencer: command source arbitration, watchdog, duty ramp / deadtime
// sequencing and shared-counter PWM for a two-motor differential drive.
module drive_sequencer #(
  parameter int unsigned RAMP_DIV  = 16,
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned DEADTIME  = 64,
  parameter int unsigned WDOG      = 5_000_000,
  parameter int unsigned TURN_DUTY = 128
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       ir_valid,
  input  logic [2:0] ir_cmd,
  input  logic       cam_valid,
  input  logic [2:0] cam_cmd,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [7:0] duty,
  output logic [1:0] seq_state,
  output logic [2:0] active_cmd,
  output logic       wdog_trip
);

  localparam logic [1:0] ST_STOPPED = 2'b00;
  localparam logic [1:0] ST_RAMP    = 2'b01;
  localparam logic [1:0] ST_HOLD    = 2'b10;
  localparam logic [1:0] ST_DEAD    = 2'b11;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_CAM  = 2'b01;
  localparam logic [1:0] MODE_IR   = 2'b10;

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_SLOW   = 3'd3;
  localparam logic [2:0] CMD_MEDIUM = 3'd4;
  localparam logic [2:0] CMD_FAST   = 3'd5;

  localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int unsigned WDOG_W = (WDOG > 1) ? $clog2(WDOG) : 1;

  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG - 1);
  localparam logic [7:0]        STEP8     = 8'(RAMP_STEP);
  localparam logic [8:0]        STEP9     = 9'(RAMP_STEP);
  localparam logic [7:0]        TURN8     = 8'(TURN_DUTY);

  // registered state
  logic [1:0]        mode_q;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [DEAD_W-1:0] dead_cnt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [7:0]        pwm_cnt;

  // next-state values
  logic [1:0]        mode_eff;
  logic              mode_chg;
  logic              sel_valid;
  logic [2:0]        sel_cmd;
  logic              accept;
  logic              wdog_exp;
  logic [2:0]        active_nxt;
  logic              trip_nxt;
  logic [WDOG_W-1:0] wdog_nxt;

  logic [7:0]        target;
  logic              req_l;
  logic              req_r;
  logic              dir_diff;
  logic [7:0]        ramp_tgt;
  logic [7:0]        gap;
  logic [7:0]        stepped;
  logic              tick;
  logic [1:0]        state_nxt;
  logic [7:0]        duty_nxt;
  logic              dir_l_nxt;
  logic              dir_r_nxt;
  logic [DEAD_W-1:0] dead_nxt;
  logic [RAMP_W-1:0] ramp_nxt;
  logic [7:0]        pwm_cnt_nxt;
  logic              pwm_nxt;

  // Source selection, command latch and watchdog next-state
  always_comb begin
    mode_eff   = (mode == 2'b11) ? MODE_IDLE : mode;
    mode_chg   = (mode_eff != mode_q);
    sel_valid  = 1'b0;
    sel_cmd    = CMD_STOP;
    accept     = 1'b0;
    wdog_exp   = 1'b0;
    active_nxt = active_cmd;
    trip_nxt   = wdog_trip;
    wdog_nxt   = wdog_cnt;

    case (mode_eff)
      MODE_CAM: begin
        sel_valid = cam_valid;
        sel_cmd   = cam_cmd;
      end
      MODE_IR: begin
        sel_valid = ir_valid;
        sel_cmd   = ir_cmd;
      end
      default: begin
        sel_valid = 1'b0;
        sel_cmd   = CMD_STOP;
      end
    endcase

    // a strobe landing in the mode-change cycle belongs to the old context
    accept   = sel_valid && !mode_chg;
    wdog_exp = (active_cmd != CMD_STOP) && (wdog_cnt == WDOG_LAST);

    if (mode_chg || (mode_eff == MODE_IDLE)) begin
      active_nxt = CMD_STOP;
    end else if (accept) begin
      active_nxt = (sel_cmd > CMD_FAST) ? CMD_STOP : sel_cmd;
    end else if (wdog_exp) begin
      active_nxt = CMD_STOP;
    end

    if (mode_chg || accept) begin
      trip_nxt = 1'b0;
    end else if (wdog_exp) begin
      trip_nxt = 1'b1;
    end

    // counts only while a moving command is latched
    if (accept || wdog_exp || (active_cmd == CMD_STOP)) begin
      wdog_nxt = '0;
    end else begin
      wdog_nxt = wdog_cnt + WDOG_W'(1);
    end
  end

  // Sequencer next-state: target/dir decode, ramp step, FSM, PWM compare
  always_comb begin
    target      = 8'd0;
    req_l       = dir_l;
    req_r       = dir_r;
    dir_diff    = 1'b0;
    ramp_tgt    = 8'd0;
    gap         = 8'd0;
    stepped     = duty;
    tick        = (ramp_cnt == RAMP_LAST);
    state_nxt   = seq_state;
    duty_nxt    = duty;
    dir_l_nxt   = dir_l;
    dir_r_nxt   = dir_r;
    dead_nxt    = dead_cnt;
    ramp_nxt    = tick ? '0 : ramp_cnt + RAMP_W'(1);
    pwm_cnt_nxt = pwm_cnt + 8'd1;
    pwm_nxt     = 1'b0;

    case (active_cmd)
      CMD_LEFT:   begin target = TURN8;  req_l = 1'b0; req_r = 1'b1; end
      CMD_RIGHT:  begin target = TURN8;  req_l = 1'b1; req_r = 1'b0; end
      CMD_SLOW:   begin target = 8'd85;  req_l = 1'b1; req_r = 1'b1; end
      CMD_MEDIUM: begin target = 8'd170; req_l = 1'b1; req_r = 1'b1; end
      CMD_FAST:   begin target = 8'd255; req_l = 1'b1; req_r = 1'b1; end
      default:    begin target = 8'd0;   req_l = dir_l; req_r = dir_r; end
    endcase

    dir_diff = (target != 8'd0) && ((req_l != dir_l) || (req_r != dir_r));
    // a pending reversal first brings the motors down to zero
    ramp_tgt = dir_diff ? 8'd0 : target;

    if (duty < ramp_tgt) begin
      gap     = ramp_tgt - duty;
      stepped = ({1'b0, gap} <= STEP9) ? ramp_tgt : duty + STEP8;
    end else begin
      gap     = duty - ramp_tgt;
      stepped = ({1'b0, gap} <= STEP9) ? ramp_tgt : duty - STEP8;
    end

    case (seq_state)
      ST_STOPPED: begin
        duty_nxt = 8'd0;
        if (target != 8'd0) begin
          if (dir_diff) begin
            state_nxt = ST_DEAD;
            dead_nxt  = '0;
          end else begin
            state_nxt = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (tick) begin
          duty_nxt = stepped;
        end
        if (dir_diff && (duty == 8'd0)) begin
          state_nxt = ST_DEAD;
          dead_nxt  = '0;
        end else if (!dir_diff && (duty == target)) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if ((target != duty) || dir_diff) begin
          state_nxt = ST_RAMP;
        end else if (target == 8'd0) begin
          state_nxt = ST_STOPPED;
        end
      end
      default: begin
        duty_nxt = 8'd0;
        if (dead_cnt == DEAD_LAST) begin
          dir_l_nxt = req_l;
          dir_r_nxt = req_r;
          state_nxt = (target != 8'd0) ? ST_RAMP : ST_STOPPED;
        end else begin
          dead_nxt = dead_cnt + DEAD_W'(1);
        end
      end
    endcase

    // dropping to IDLE cuts drive immediately, bypassing the ramp
    if (mode_chg && (mode_eff == MODE_IDLE)) begin
      state_nxt = ST_STOPPED;
      duty_nxt  = 8'd0;
    end

    pwm_nxt = (pwm_cnt_nxt < duty_nxt) && (state_nxt != ST_DEAD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_50) begin
    if (reset) begin
      mode_q     <= mode_eff;
      active_cmd <= CMD_STOP;
      wdog_trip  <= 1'b0;
      wdog_cnt   <= '0;
      ramp_cnt   <= '0;
      dead_cnt   <= '0;
      pwm_cnt    <= 8'd0;
      seq_state  <= ST_STOPPED;
      duty       <= 8'd0;
      dir_l      <= 1'b1;
      dir_r      <= 1'b1;
      pwm_l      <= 1'b0;
      pwm_r      <= 1'b0;
    end else begin
      mode_q     <= mode_eff;
      active_cmd <= active_nxt;
      wdog_trip  <= trip_nxt;
      wdog_cnt   <= wdog_nxt;
      ramp_cnt   <= ramp_nxt;
      dead_cnt   <= dead_nxt;
      pwm_cnt    <= pwm_cnt_nxt;
      seq_state  <= state_nxt;
      duty       <= duty_nxt;
      dir_l      <= dir_l_nxt;
      dir_r      <= dir_r_nxt;
      pwm_l      <= pwm_nxt;
      pwm_r      <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a timestamp-based behavioural model of the drive sequencer.
module tb_drive_sequencer;

  localparam int RDIV = 4;
  localparam int STEP = 17;
  localparam int DT   = 8;
  localparam int WD   = 200;
  localparam int TURN = 128;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       ir_valid;
  logic [2:0] ir_cmd;
  logic       cam_valid;
  logic [2:0] cam_cmd;
  logic       pwm_l, pwm_r, dir_l, dir_r, wdog_trip;
  logic [7:0] duty;
  logic [1:0] seq_state;
  logic [2:0] active_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int dead_seen = 0;
  logic [1:0] cur_mode = 2'b00;

  // model state (values the DUT registers should hold after the last edge)
  int m_mode_prev, m_act, m_trip, m_acc_stamp, m_cyc;
  int m_state, m_duty, m_dl, m_dr, m_dead_last, m_pwm;

  drive_sequencer #(
    .RAMP_DIV(RDIV), .RAMP_STEP(STEP), .DEADTIME(DT), .WDOG(WD), .TURN_DUTY(TURN)
  ) dut (
    .clk_50(clk_50), .reset(reset), .mode(mode),
    .ir_valid(ir_valid), .ir_cmd(ir_cmd),
    .cam_valid(cam_valid), .cam_cmd(cam_cmd),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .duty(duty), .seq_state(seq_state), .active_cmd(active_cmd), .wdog_trip(wdog_trip)
  );

  // 50 MHz-style free-running clock
  always #5 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt_of(input int c);
    case (c)
      1, 2:    return TURN;
      3:       return 85;
      4:       return 170;
      5:       return 255;
      default: return 0;
    endcase
  endfunction

  function automatic int want_l(input int c, input int cur);
    if (c == 1) return 0;
    if (c >= 2 && c <= 5) return 1;
    return cur;
  endfunction

  function automatic int want_r(input int c, input int cur);
    if (c == 2) return 0;
    if (c == 1 || (c >= 3 && c <= 5)) return 1;
    return cur;
  endfunction

  // advance the model across one clock edge with the given inputs
  task automatic model_step(input int r, input int md, input int iv, input int ic,
                            input int cv, input int cc);
    int eff, sv, sc, acc, expire, tgt, wl, wr, flip, aim, tick;
    int nst, nd, ndl, ndr, ndead, nact, ntrip, chg;
    eff = (md == 3) ? 0 : md;
    if (r != 0) begin
      m_mode_prev = eff; m_act = 0; m_trip = 0; m_acc_stamp = 0; m_cyc = 0;
      m_state = 0; m_duty = 0; m_dl = 1; m_dr = 1; m_dead_last = 0; m_pwm = 0;
      return;
    end
    chg = (eff != m_mode_prev) ? 1 : 0;
    sv  = (eff == 1) ? cv : (eff == 2) ? iv : 0;
    sc  = (eff == 1) ? cc : (eff == 2) ? ic : 0;
    acc = (sv != 0 && chg == 0) ? 1 : 0;
    expire = (m_act != 0 && (m_cyc - m_acc_stamp) == WD - 1) ? 1 : 0;

    nact = m_act; ntrip = m_trip;
    if (chg != 0 || eff == 0) nact = 0;
    else if (acc != 0) nact = (sc > 5) ? 0 : sc;
    else if (expire != 0) nact = 0;
    if (chg != 0 || acc != 0) ntrip = 0;
    else if (expire != 0) ntrip = 1;

    tgt  = tgt_of(m_act);
    wl   = want_l(m_act, m_dl);
    wr   = want_r(m_act, m_dr);
    flip = (tgt != 0 && (wl != m_dl || wr != m_dr)) ? 1 : 0;
    aim  = (flip != 0) ? 0 : tgt;
    tick = ((m_cyc % RDIV) == RDIV - 1) ? 1 : 0;
    nst = m_state; nd = m_duty; ndl = m_dl; ndr = m_dr; ndead = m_dead_last;
    case (m_state)
      0: begin
        nd = 0;
        if (tgt != 0) begin
          if (flip != 0) begin nst = 3; ndead = m_cyc + DT; end
          else nst = 1;
        end
      end
      1: begin
        if (tick != 0) begin
          if (m_duty < aim) nd = (m_duty + STEP > aim) ? aim : m_duty + STEP;
          else              nd = (m_duty - STEP < aim) ? aim : m_duty - STEP;
        end
        if (flip != 0 && m_duty == 0) begin nst = 3; ndead = m_cyc + DT; end
        else if (flip == 0 && m_duty == tgt) nst = 2;
      end
      2: begin
        if (tgt != m_duty || flip != 0) nst = 1;
        else if (tgt == 0) nst = 0;
      end
      default: begin
        nd = 0;
        if (m_cyc == m_dead_last) begin
          ndl = wl; ndr = wr;
          nst = (tgt != 0) ? 1 : 0;
        end
      end
    endcase
    if (chg != 0 && eff == 0) begin nst = 0; nd = 0; end

    if (acc != 0) m_acc_stamp = m_cyc + 1;
    m_cyc = m_cyc + 1;
    m_mode_prev = eff; m_act = nact; m_trip = ntrip;
    m_state = nst; m_duty = nd; m_dl = ndl; m_dr = ndr; m_dead_last = ndead;
    m_pwm = ((m_cyc % 256) < m_duty && m_state != 3) ? 1 : 0;
  endtask

  // drive one cycle of inputs, step the model, compare every output
  task automatic cycle(input logic r, input logic [1:0] md, input logic iv, input logic [2:0] ic,
                       input logic cv, input logic [2:0] cc);
    @(negedge clk_50);
    reset = r; mode = md; ir_valid = iv; ir_cmd = ic; cam_valid = cv; cam_cmd = cc;
    cur_mode = md;
    model_step(int'(r), int'(md), int'(iv), int'(ic), int'(cv), int'(cc));
    @(posedge clk_50);
    #1;
    if (seq_state == 2'b11) dead_seen++;
    check("seq_state",  32'(seq_state),  m_state);
    check("duty",       32'(duty),       m_duty);
    check("active_cmd", 32'(active_cmd), m_act);
    check("wdog_trip",  32'(wdog_trip),  m_trip);
    check("dir_l",      32'(dir_l),      m_dl);
    check("dir_r",      32'(dir_r),      m_dr);
    check("pwm_l",      32'(pwm_l),      m_pwm);
    check("pwm_r",      32'(pwm_r),      m_pwm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, cur_mode, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic ir_strobe(input logic [2:0] c);
    cycle(1'b0, cur_mode, 1'b1, c, 1'b0, 3'd0);
  endtask

  initial begin
    int rate;
    logic [1:0] md;
    reset = 1'b1; mode = 2'b10; ir_valid = 1'b0; ir_cmd = 3'd0;
    cam_valid = 1'b0; cam_cmd = 3'd0;

    // reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
    check("rst_state", 32'(seq_state), 0);
    check("rst_duty",  32'(duty), 0);
    check("rst_dirs",  32'({dir_l, dir_r}), 3);

    // FAST ramp to 255 and hold
    idle(2);
    ir_strobe(3'd5);
    idle(80);
    check("fast_duty", 32'(duty), 255);
    check("fast_hold", 32'(seq_state), 2);
    check("fast_dirs", 32'({dir_l, dir_r}), 3);

    // reversal to LEFT through exactly DT dead cycles
    dead_seen = 0;
    ir_strobe(3'd1);
    idle(130);
    check("left_dead_cycles", 32'(dead_seen), DT);
    check("left_duty", 32'(duty), TURN);
    check("left_dirs", 32'({dir_l, dir_r}), 1);

    // CAM mode ignores simultaneous IR strobe
    cycle(1'b0, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b0, 2'b01, 1'b1, 3'd5, 1'b1, 3'd3);
    check("cam_select", 32'(active_cmd), 3);
    idle(40);

    // watchdog trip and clear
    cycle(1'b0, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
    idle(2);
    ir_strobe(3'd4);
    idle(205);
    check("wdog_act",  32'(active_cmd), 0);
    check("wdog_trip", 32'(wdog_trip), 1);
    idle(60);
    check("wdog_duty0", 32'(duty), 0);
    ir_strobe(3'd3);
    check("wdog_clear", 32'(wdog_trip), 0);

    // drop to IDLE mid-ramp at duty 102
    ir_strobe(3'd5);
    for (int i = 0; i < 200 && duty != 8'd102; i++) idle(1);
    check("reach_102", 32'(duty), 102);
    cycle(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
    check("idle_duty", 32'(duty), 0);
    check("idle_state", 32'(seq_state), 0);

    // illegal code latches as STOP
    cycle(1'b0, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
    idle(2);
    ir_strobe(3'd5);
    idle(10);
    ir_strobe(3'd6);
    check("code110", 32'(active_cmd), 0);

    // reset mid-ramp
    ir_strobe(3'd5);
    idle(10);
    cycle(1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
    check("midrst_duty", 32'(duty), 0);
    check("midrst_state", 32'(seq_state), 0);
    idle(3);

    // randomized traffic with varying strobe density
    for (int blk = 0; blk < 20; blk++) begin
      rate = 10 + int'($urandom_range(0, 390));
      for (int i = 0; i < 1000; i++) begin
        md = cur_mode;
        if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
        cycle(($urandom_range(0, 4999) == 0) ? 1'b1 : 1'b0, md,
              ($urandom_range(0, rate - 1) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
              ($urandom_range(0, rate - 1) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)));
      end
      if (md == 2'b00 || md == 2'b11) cycle(1'b0, 2'($urandom_range(1, 2)), 1'b0, 3'd0, 1'b0, 3'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
